design01_nios2_gen2_0_cpu_ocimem_arbiter: RTL and testbench
===========================================================

// Module: design01_nios2_gen2_0_cpu_ocimem_arbiter
// PURPOSE
//  Shares the single-port OCI debug RAM between the JTAG debug slave (take_action_ocimem_* pulses + jdo)
//  and the CPU-side Avalon debug_mem_slave. Sequences each access through a one-at-a-time FSM, auto-
//  increments the JTAG address, and returns JTAG read data on mon_dreg. Sits in the sysclk domain
//  between the debug slave sysclk logic and the OCI RAM.
// PARAMETERS
//  ADDR_W   8   word-address width of OCI RAM; JTAG address wraps modulo 2**ADDR_W
//  DATA_W   32  RAM/Avalon data width; fixed at 32 (jdo payload width)
// PORTS
//  clk                      in   1       system clock
//  reset                    in   1       synchronous, active-high reset
//  take_action_ocimem_a     in   1       JTAG: load addr = jdo[17+ADDR_W-1:17]; if jdo[35] also read there
//  take_action_ocimem_b     in   1       JTAG: write jdo[34:3] at jtag addr, then addr+1
//  take_no_action_ocimem_a  in   1       JTAG: read at jtag addr, then addr+1
//  jdo                      in   38      JTAG command/data word, valid with the pulses above
//  debugack                 in   1       CPU in debug mode; JTAG writes permitted only when 1
//  ovr_clr                  in   1       clears jtag_overrun and jtag_err
//  av_address               in   ADDR_W  CPU Avalon word address
//  av_read / av_write       in   1       CPU Avalon strobes (held until waitrequest low)
//  av_writedata             in   DATA_W  CPU write data
//  av_byteenable            in   4       CPU byte enables
//  av_readdata              out  DATA_W  CPU read data, valid when av_waitrequest=0 on a read
//  av_waitrequest           out  1       Avalon stall
//  ram_addr                 out  ADDR_W  OCI RAM address
//  ram_wdata                out  DATA_W  OCI RAM write data
//  ram_be                   out  4       OCI RAM byte enables (JTAG writes use 4'hF)
//  ram_wren / ram_rden      out  1       OCI RAM strobes, one-cycle
//  ram_rdata                in   DATA_W  OCI RAM read data, 1-cycle latency after ram_rden
//  mon_dreg                 out  32      last JTAG read data
//  mon_valid                out  1       one-cycle pulse when mon_dreg updated
//  jtag_overrun             out  1       sticky: JTAG pulse lost (pending slot full)
//  jtag_err                 out  1       sticky: JTAG write rejected (debugack=0)
// BEHAVIOUR
//  Reset: state IDLE, jtag addr 0, pending empty, last_grant=CPU, av_waitrequest=1, ram_* strobes 0,
//   ram_addr/wdata/be 0, av_readdata 0, mon_dreg 0, mon_valid 0, jtag_overrun 0, jtag_err 0.
//  JTAG capture: any pulse loads a 1-deep pending reg {op, addr, data}. Pulse while pending full, or a
//   second pulse in the same cycle (priority ocimem_a > ocimem_b > no_action_a) -> dropped, jtag_overrun=1.
//   ocimem_a without jdo[35]: updates addr only, no RAM access, never occupies pending.
//  Arbitration in IDLE: 2-way round-robin between jtag pending and CPU (av_read|av_write); on tie the
//   requester not in last_grant wins; last_grant updates on every grant.
//  FSM: IDLE -> ACCESS (ram_rden or ram_wren high 1 cycle, ram_* from registered command)
//   read: ACCESS -> RDATA (capture ram_rdata into rdata_q) -> DONE;  write: ACCESS -> DONE;  DONE -> IDLE.
//   Latency from grant cycle: read 3 cycles to DONE, write 2 cycles. Next grant earliest in cycle after DONE.
//  DONE, CPU owner: av_waitrequest=0 for exactly 1 cycle, av_readdata=rdata_q. Otherwise av_waitrequest=1.
//  DONE, JTAG read: mon_dreg<=rdata_q, mon_valid pulse; pending cleared; addr+1 (wraps to 0) for
//   no_action_a and ocimem_b. ocimem_a+read does not increment.
//  JTAG write with debugack=0: granted, no ram_wren, jtag_err=1, addr still increments, pending cleared.
//  New JTAG pulse in DONE of a JTAG op is accepted (pending frees same edge).
//  ovr_clr and a new overrun in the same cycle: flag stays 1.
//  CPU dropping av_read/av_write mid-op is illegal; op completes regardless.
//  reset mid-op: abort immediately, no further RAM strobes, all outputs to reset values.
// STRUCTURE
//  Package design01_nios2_gen2_0_cpu_ocimem_pkg: FSM state encoding, op codes, jdo field positions
//   (addr lsb 17, data [34:3], read flag 35).
//  Sub-module design01_nios2_gen2_0_cpu_ocimem_rr_arb: 2-requester round-robin with last_grant reg.
// TESTING
//  1 CPU read addr 0x05 (RAM holds 0xDEADBEEF), no JTAG -> ram_rden at +1, waitrequest low at +3, readdata 0xDEADBEEF.
//  2 debugack=1; ocimem_a addr 0xFE no read; ocimem_b x3 data 1,2,3 -> RAM[0xFE]=1, [0xFF]=2, [0x00]=3 (wrap).
//  3 CPU write and JTAG read same cycle after reset -> JTAG served first, CPU next; repeat tie -> CPU first.
//  4 Two no_action_a pulses 1 cycle apart while busy -> second dropped, jtag_overrun=1; ovr_clr -> 0.
//  5 debugack=0, ocimem_b -> no ram_wren, jtag_err=1, addr advances by 1.
//  6 reset asserted during RDATA of JTAG read -> no mon_valid, state IDLE, addr 0, av_waitrequest=1.

Source files
------------

// File: rtl/design01_nios2_gen2_0_cpu_ocimem_pkg.sv
// Shared types and constants for the OCI debug RAM arbiter.
//   state_e : access sequencer states
//   op_e    : JTAG command held in the pending slot
//   owner_e : which side owns the in-flight RAM access
//   JDO_*   : field positions inside the 38-bit jdo command word
package design01_nios2_gen2_0_cpu_ocimem_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RDATA, ST_DONE} state_e;
  typedef enum logic [1:0] {OP_RD_A, OP_WR_B, OP_RD_N} op_e;
  typedef enum logic {OWN_CPU = 1'b0, OWN_JTAG = 1'b1} owner_e;

  localparam int JDO_W        = 38;
  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_RD_BIT   = 35;
  localparam logic [3:0] BE_ALL = 4'hF;
endpackage

// File: rtl/design01_nios2_gen2_0_cpu_ocimem_arbiter_if.sv
// CPU-side Avalon debug_mem_slave bus.
//   master : CPU (drives address/strobes/write data, sees readdata/waitrequest)
//   slave  : arbiter
interface design01_nios2_gen2_0_cpu_ocimem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [3:0]        byteenable;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (output address, read, write, writedata, byteenable,
                  input  readdata, waitrequest);
  modport slave  (input  address, read, write, writedata, byteenable,
                  output readdata, waitrequest);
endinterface

// File: rtl/design01_nios2_gen2_0_cpu_ocimem_rr_arb.sv
// Two-requester round-robin (JTAG vs CPU).
//   clk, reset : clock, synchronous active-high reset
//   en         : arbitrate this cycle (sequencer idle)
//   req_jtag/req_cpu -> gnt_jtag/gnt_cpu (one-hot or none)
// On a tie the requester that did not win last time gets the grant.
module design01_nios2_gen2_0_cpu_ocimem_rr_arb
  import design01_nios2_gen2_0_cpu_ocimem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_jtag,
  input  logic req_cpu,
  output logic gnt_jtag,
  output logic gnt_cpu
);
  owner_e last_grant;

  always_comb begin
    gnt_jtag = en && req_jtag && (!req_cpu || last_grant == OWN_CPU);
    gnt_cpu  = en && req_cpu && !gnt_jtag;
  end

  always_ff @(posedge clk) begin
    if (reset)         last_grant <= OWN_CPU;
    else if (gnt_jtag) last_grant <= OWN_JTAG;
    else if (gnt_cpu)  last_grant <= OWN_CPU;
  end
endmodule

// File: rtl/design01_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG debug slave and the
// CPU Avalon debug_mem_slave, one access at a time.
//   clk, reset              : sysclk, synchronous active-high reset
//   take_action_ocimem_a/b, take_no_action_ocimem_a, jdo : JTAG commands
//   debugack                : JTAG writes allowed only while set
//   ovr_clr                 : clears jtag_overrun / jtag_err
//   av                      : Avalon slave port (CPU)
//   ram_*                   : OCI RAM port, rdata 1 cycle after ram_rden
//   mon_dreg/mon_valid      : JTAG read return
//   jtag_overrun/jtag_err   : sticky error flags
module design01_nios2_gen2_0_cpu_ocimem_arbiter
  import design01_nios2_gen2_0_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 take_action_ocimem_a,
  input  logic                 take_action_ocimem_b,
  input  logic                 take_no_action_ocimem_a,
  input  logic [JDO_W-1:0]     jdo,
  input  logic                 debugack,
  input  logic                 ovr_clr,
  design01_nios2_gen2_0_cpu_ocimem_arbiter_if.slave av,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_wdata,
  output logic [3:0]           ram_be,
  output logic                 ram_wren,
  output logic                 ram_rden,
  input  logic [DATA_W-1:0]    ram_rdata,
  output logic [31:0]          mon_dreg,
  output logic                 mon_valid,
  output logic                 jtag_overrun,
  output logic                 jtag_err
);
  state_e            state_q, state_d;
  owner_e            owner_q;
  logic              cmd_wr_q, cmd_en_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_data_q, rdata_q;
  logic [3:0]        cmd_be_q;

  logic              pend_vld_q;
  op_e               pend_op_q;
  logic [ADDR_W-1:0] pend_addr_q, jaddr_q;
  logic [31:0]       pend_data_q;

  logic              gnt_jtag, gnt_cpu, jtag_done, slot_free, any_pulse, accept, load, lost;
  logic [1:0]        n_pulse;
  op_e               new_op, eff_op;
  logic [ADDR_W-1:0] jdo_addr, jaddr_base, jaddr_d, new_addr, eff_addr;
  logic [31:0]       eff_data;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LSB-1:0]};

  // JTAG capture. The slot frees on the DONE edge of its own op, so a pulse
  // landing in that cycle is taken. A pulse captured while idle is visible to
  // the arbiter in the same cycle (eff_*), so JTAG and CPU can tie.
  always_comb begin
    jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
    jtag_done  = state_q == ST_DONE && owner_q == OWN_JTAG;
    slot_free  = !pend_vld_q || jtag_done;
    jaddr_base = (jtag_done && pend_op_q != OP_RD_A) ? pend_addr_q + ADDR_W'(1) : jaddr_q;
    n_pulse    = 2'(take_action_ocimem_a) + 2'(take_action_ocimem_b) + 2'(take_no_action_ocimem_a);
    any_pulse  = n_pulse != 2'd0;
    accept     = any_pulse && slot_free;
    lost       = any_pulse && (!slot_free || n_pulse > 2'd1);
    // ocimem_a without the read flag is an address load only
    load       = accept && (!take_action_ocimem_a || jdo[JDO_RD_BIT]);
    new_op     = take_action_ocimem_a ? OP_RD_A : take_action_ocimem_b ? OP_WR_B : OP_RD_N;
    new_addr   = take_action_ocimem_a ? jdo_addr : jaddr_base;
    jaddr_d    = (accept && take_action_ocimem_a) ? jdo_addr : jaddr_base;
    eff_op     = load ? new_op : pend_op_q;
    eff_addr   = load ? new_addr : pend_addr_q;
    eff_data   = load ? jdo[JDO_DATA_MSB:JDO_DATA_LSB] : pend_data_q;
  end

  design01_nios2_gen2_0_cpu_ocimem_rr_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .en       (state_q == ST_IDLE),
    .req_jtag (pend_vld_q || load),
    .req_cpu  (av.read || av.write),
    .gnt_jtag (gnt_jtag),
    .gnt_cpu  (gnt_cpu)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (gnt_jtag || gnt_cpu) state_d = ST_ACCESS;
      ST_ACCESS: state_d = cmd_wr_q ? ST_DONE : ST_RDATA;
      ST_RDATA:  state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld_q <= 1'b0;  pend_op_q <= OP_RD_N;  pend_addr_q <= '0;  pend_data_q <= '0;
      jaddr_q    <= '0;
      owner_q    <= OWN_CPU;  cmd_wr_q <= 1'b0;  cmd_en_q <= 1'b0;
      cmd_addr_q <= '0;  cmd_data_q <= '0;  cmd_be_q <= '0;
      rdata_q    <= '0;  mon_dreg <= '0;  mon_valid <= 1'b0;
      jtag_overrun <= 1'b0;  jtag_err <= 1'b0;
    end else begin
      jaddr_q <= jaddr_d;
      if (load) begin
        pend_vld_q <= 1'b1;  pend_op_q <= new_op;
        pend_addr_q <= new_addr;  pend_data_q <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
      end else if (jtag_done) begin
        pend_vld_q <= 1'b0;
      end

      if (gnt_jtag) begin
        owner_q    <= OWN_JTAG;
        cmd_wr_q   <= eff_op == OP_WR_B;
        cmd_en_q   <= debugack;   // rejected write still runs the sequence, without ram_wren
        cmd_addr_q <= eff_addr;
        cmd_data_q <= DATA_W'(eff_data);
        cmd_be_q   <= BE_ALL;
      end else if (gnt_cpu) begin
        owner_q    <= OWN_CPU;
        cmd_wr_q   <= av.write;
        cmd_en_q   <= 1'b1;
        cmd_addr_q <= av.address;
        cmd_data_q <= av.writedata;
        cmd_be_q   <= av.byteenable;
      end

      if (state_q == ST_RDATA) rdata_q <= ram_rdata;
      mon_valid <= jtag_done && !cmd_wr_q;
      if (jtag_done && !cmd_wr_q) mon_dreg <= 32'(rdata_q);

      // set wins over clear
      jtag_overrun <= lost || (jtag_overrun && !ovr_clr);
      jtag_err     <= (gnt_jtag && eff_op == OP_WR_B && !debugack) || (jtag_err && !ovr_clr);
    end
  end

  // Gated by reset so an aborted op issues no strobe in the reset cycle.
  always_comb begin
    ram_addr = '0;  ram_wdata = '0;  ram_be = '0;  ram_rden = 1'b0;  ram_wren = 1'b0;
    av.waitrequest = 1'b1;  av.readdata = '0;
    if (!reset) begin
      ram_addr  = cmd_addr_q;
      ram_wdata = cmd_data_q;
      ram_be    = cmd_be_q;
      ram_rden  = state_q == ST_ACCESS && !cmd_wr_q;
      ram_wren  = state_q == ST_ACCESS && cmd_wr_q && cmd_en_q;
      av.waitrequest = !(state_q == ST_DONE && owner_q == OWN_CPU);
      av.readdata    = rdata_q;
    end
  end
endmodule

// File: tb/tb_design01_nios2_gen2_0_cpu_ocimem_arbiter.sv
module tb_design01_nios2_gen2_0_cpu_ocimem_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ta_a = 1'b0, ta_b = 1'b0, tn_a = 1'b0;
  logic [37:0] jdo = '0;
  logic debugack = 1'b0, ovr_clr = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [3:0] ram_be;
  logic ram_wren, ram_rden;
  logic [31:0] mon_dreg;
  logic mon_valid, jtag_overrun, jtag_err;

  design01_nios2_gen2_0_cpu_ocimem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) av();

  design01_nios2_gen2_0_cpu_ocimem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b), .take_no_action_ocimem_a(tn_a),
    .jdo(jdo), .debugack(debugack), .ovr_clr(ovr_clr), .av(av),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_wren(ram_wren),
    .ram_rden(ram_rden), .ram_rdata(ram_rdata), .mon_dreg(mon_dreg), .mon_valid(mon_valid),
    .jtag_overrun(jtag_overrun), .jtag_err(jtag_err)
  );

  always #5 clk = ~clk;

  // RAM environment model plus monitors
  logic [31:0] ram [256];
  logic        seed_en = 1'b0;
  logic [7:0]  seed_addr = '0;
  logic [31:0] seed_val = '0;
  int rden_cnt = 0, wren_cnt = 0, mon_cnt = 0;
  logic [31:0] mon_last = '0;
  logic [8:0] acc_log [$];

  always @(posedge clk) begin
    if (seed_en) ram[seed_addr] = seed_val;
    if (ram_wren) begin
      for (int i = 0; i < 4; i++) if (ram_be[i]) ram[ram_addr][8*i +: 8] = ram_wdata[8*i +: 8];
      wren_cnt++;
      acc_log.push_back({1'b1, ram_addr});
    end
    if (ram_rden) begin
      ram_rdata <= ram[ram_addr];
      rden_cnt++;
      acc_log.push_back({1'b0, ram_addr});
    end
    if (mon_valid) begin mon_cnt++; mon_last = mon_dreg; end
  end

  // reference model: memory contents, JTAG address, sticky error
  logic [31:0] ref_mem [256];
  logic [7:0]  ref_jaddr = '0;
  logic        ref_err = 1'b0;
  int checks = 0, errors = 0;

  function automatic void ref_cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
  endfunction

  function automatic void ref_jtag(input int kind, input logic [7:0] a, input logic rd, input logic [31:0] d,
                                   input logic dbg, output int exp_n, output logic [31:0] exp_v);
    exp_n = 0; exp_v = '0;
    case (kind)
      0: begin ref_jaddr = a; if (rd) begin exp_n = 1; exp_v = ref_mem[a]; end end
      1: begin if (dbg) ref_mem[ref_jaddr] = d; else ref_err = 1'b1; ref_jaddr = ref_jaddr + 8'd1; end
      default: begin exp_n = 1; exp_v = ref_mem[ref_jaddr]; ref_jaddr = ref_jaddr + 8'd1; end
    endcase
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic seed(input logic [7:0] a, input logic [31:0] v);
    seed_addr = a; seed_val = v; seed_en = 1'b1;
    step(1);
    seed_en = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(2); reset = 1'b0;
    ref_jaddr = '0; ref_err = 1'b0;
  endtask

  // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_a
  task automatic jtag_pulse(input int kind, input logic [7:0] a, input logic rd, input logic [31:0] d);
    jdo = '0; jdo[34:3] = d;
    if (kind == 0) begin jdo[24:17] = a; jdo[35] = rd; end
    ta_a = kind == 0; ta_b = kind == 1; tn_a = kind == 2;
    step(1);
    ta_a = 1'b0; ta_b = 1'b0; tn_a = 1'b0;
  endtask

  task automatic jtag_op(input int kind, input logic [7:0] a, input logic rd, input logic [31:0] d,
                         output int nrd, output logic [31:0] rv);
    int mc;
    mc = mon_cnt;
    jtag_pulse(kind, a, rd, d);
    step(6);
    nrd = mon_cnt - mc; rv = mon_last;
  endtask

  task automatic cpu_op(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rd, output int lat);
    av.address = a; av.writedata = d; av.byteenable = be; av.read = !wr; av.write = wr;
    lat = 0;
    do begin step(1); lat++; end while (av.waitrequest && lat < 40);
    rd = av.readdata;
    step(1);
    av.read = 1'b0; av.write = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) seed(8'(i), $urandom);
    checks++; if (av.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_waitreq: got %b want 1", av.waitrequest); end
    checks++; if ({ram_rden, ram_wren} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {ram_rden, ram_wren}); end
    checks++; if ({ram_addr, ram_wdata, ram_be} !== '0) begin errors++; $display("FAIL reset_ram_bus: got %h want 0", {ram_addr, ram_wdata, ram_be}); end
    checks++; if (av.readdata !== '0) begin errors++; $display("FAIL reset_readdata: got %h want 0", av.readdata); end
    checks++; if ({mon_dreg, mon_valid, jtag_overrun, jtag_err} !== '0) begin errors++;
      $display("FAIL reset_mon_flags: got %h want 0", {mon_dreg, mon_valid, jtag_overrun, jtag_err}); end
    reset = 1'b0;
    step(1);
    checks++; if (av.waitrequest !== 1'b1) begin errors++; $display("FAIL idle_waitreq: got %b want 1", av.waitrequest); end
  endtask

  task automatic test_cpu_read();
    logic [31:0] rd; int lat;
    seed(8'h05, 32'hDEADBEEF);
    av.address = 8'h05; av.byteenable = 4'hF; av.read = 1'b1;
    step(1);
    checks++; if (ram_rden !== 1'b1 || ram_addr !== 8'h05) begin errors++;
      $display("FAIL cpu_rd_rden: got rden=%b addr=%h want 1/05", ram_rden, ram_addr); end
    step(1);
    checks++; if (av.waitrequest !== 1'b1) begin errors++; $display("FAIL cpu_rd_wait2: got %b want 1", av.waitrequest); end
    step(1);
    checks++; if (av.waitrequest !== 1'b0 || av.readdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL cpu_rd_done: got wr=%b data=%h want 0/deadbeef", av.waitrequest, av.readdata); end
    step(1);
    av.read = 1'b0;
    checks++; if (av.waitrequest !== 1'b1) begin errors++; $display("FAIL cpu_rd_one_cycle: got %b want 1", av.waitrequest); end
    cpu_op(1'b1, 8'h06, 32'hA5A5_1234, 4'b0101, rd, lat);
    ref_cpu_wr(8'h06, 32'hA5A5_1234, 4'b0101);
    checks++; if (lat !== 2) begin errors++; $display("FAIL cpu_wr_latency: got %0d want 2", lat); end
    checks++; if (ram[6] !== ref_mem[6]) begin errors++; $display("FAIL cpu_wr_be: got %h want %h", ram[6], ref_mem[6]); end
  endtask

  task automatic test_jtag_write_wrap();
    int n, en; logic [31:0] v, ev;
    debugack = 1'b1;
    ref_jtag(0, 8'hFE, 1'b0, 0, 1'b1, en, ev);
    jtag_op(0, 8'hFE, 1'b0, 0, n, v);
    checks++; if (n !== en) begin errors++; $display("FAIL addr_load_no_read: got %0d reads want %0d", n, en); end
    for (int i = 1; i <= 3; i++) begin
      ref_jtag(1, 0, 1'b0, 32'(i), 1'b1, en, ev);
      jtag_op(1, 0, 1'b0, 32'(i), n, v);
    end
    checks++; if (ram[8'hFE] !== 32'd1) begin errors++; $display("FAIL wr_fe: got %h want 1", ram[8'hFE]); end
    checks++; if (ram[8'hFF] !== 32'd2) begin errors++; $display("FAIL wr_ff: got %h want 2", ram[8'hFF]); end
    checks++; if (ram[8'h00] !== 32'd3) begin errors++; $display("FAIL wr_wrap_00: got %h want 3", ram[8'h00]); end
    ref_jtag(2, 0, 1'b0, 0, 1'b1, en, ev);
    jtag_op(2, 0, 1'b0, 0, n, v);
    checks++; if (n !== 1 || v !== ev) begin errors++; $display("FAIL rd_after_wrap: got %0d/%h want 1/%h", n, v, ev); end
  endtask

  task automatic test_tie();
    int base, lat, mc, en; logic [31:0] rd, ev0, ev1, wd;
    seed(8'h00, $urandom); seed(8'h01, $urandom);
    wd = $urandom;
    do_reset();
    base = acc_log.size(); mc = mon_cnt;
    ev0 = ref_mem[0]; ev1 = ref_mem[1];
    fork
      cpu_op(1'b1, 8'h10, wd, 4'hF, rd, lat);
      begin jtag_pulse(2, 0, 1'b0, 0); step(2); jtag_pulse(2, 0, 1'b0, 0); end
    join
    step(8);
    ref_cpu_wr(8'h10, wd, 4'hF);
    ref_jtag(2, 0, 1'b0, 0, 1'b1, en, ev0);
    ref_jtag(2, 0, 1'b0, 0, 1'b1, en, ev1);
    checks++; if (acc_log.size() < base + 3) begin errors++; $display("FAIL tie_count: got %0d want 3", acc_log.size() - base); end
    else begin
      checks++; if (acc_log[base] !== 9'h000) begin errors++; $display("FAIL tie_first_jtag: got %h want 000", acc_log[base]); end
      checks++; if (acc_log[base+1] !== 9'h110) begin errors++; $display("FAIL tie_then_cpu: got %h want 110", acc_log[base+1]); end
      checks++; if (acc_log[base+2] !== 9'h001) begin errors++; $display("FAIL tie_rr_jtag: got %h want 001", acc_log[base+2]); end
    end
    checks++; if (lat !== 6) begin errors++; $display("FAIL tie_cpu_latency: got %0d want 6", lat); end
    checks++; if (mon_cnt - mc !== 2 || mon_last !== ev1) begin errors++;
      $display("FAIL tie_mon: got %0d/%h want 2/%h", mon_cnt - mc, mon_last, ev1); end
  endtask

  task automatic test_overrun();
    int mc, lat, en; logic [31:0] rd, ev;
    mc = mon_cnt;
    ref_jtag(2, 0, 1'b0, 0, 1'b1, en, ev);
    fork
      cpu_op(1'b0, 8'h33, 0, 4'hF, rd, lat);
      begin step(1); jtag_pulse(2, 0, 1'b0, 0); jtag_pulse(2, 0, 1'b0, 0); end
    join
    step(8);
    checks++; if (jtag_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", jtag_overrun); end
    checks++; if (mon_cnt - mc !== 1 || mon_last !== ev) begin errors++;
      $display("FAIL overrun_one_read: got %0d/%h want 1/%h", mon_cnt - mc, mon_last, ev); end
    checks++; if (rd !== ref_mem[8'h33]) begin errors++; $display("FAIL overrun_cpu_rd: got %h want %h", rd, ref_mem[8'h33]); end
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
    checks++; if (jtag_overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", jtag_overrun); end
    // two pulses in one cycle with ovr_clr: ocimem_a (addr only) wins, flag stays set
    jdo = '0; jdo[24:17] = 8'h20; ta_a = 1'b1; tn_a = 1'b1; ovr_clr = 1'b1;
    step(1);
    ta_a = 1'b0; tn_a = 1'b0; ovr_clr = 1'b0;
    ref_jaddr = 8'h20;
    checks++; if (jtag_overrun !== 1'b1) begin errors++; $display("FAIL overrun_vs_clr: got %b want 1", jtag_overrun); end
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
    step(4);
    checks++; if (mon_cnt - mc !== 1) begin errors++; $display("FAIL same_cycle_dropped: got %0d reads want 1", mon_cnt - mc); end
  endtask

  task automatic test_debugack();
    int wc, n, en; logic [7:0] a0; logic [31:0] v, ev, old;
    a0 = ref_jaddr; old = ref_mem[a0];
    debugack = 1'b0; wc = wren_cnt;
    ref_jtag(1, 0, 1'b0, 32'h1357_9BDF, 1'b0, en, ev);
    jtag_op(1, 0, 1'b0, 32'h1357_9BDF, n, v);
    checks++; if (wren_cnt !== wc) begin errors++; $display("FAIL noack_wren: got %0d strobes want 0", wren_cnt - wc); end
    checks++; if (jtag_err !== 1'b1) begin errors++; $display("FAIL noack_err: got %b want 1", jtag_err); end
    checks++; if (ram[a0] !== old) begin errors++; $display("FAIL noack_ram: got %h want %h", ram[a0], old); end
    ref_jtag(2, 0, 1'b0, 0, 1'b0, en, ev);
    jtag_op(2, 0, 1'b0, 0, n, v);
    checks++; if (n !== 1 || v !== ev) begin errors++; $display("FAIL noack_addr_adv: got %0d/%h want 1/%h", n, v, ev); end
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0; ref_err = 1'b0;
    checks++; if (jtag_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", jtag_err); end
    debugack = 1'b1;
  endtask

  task automatic test_reset_midop();
    int mc, rc, n, en, lat; logic [31:0] v, ev, rd;
    seed(8'h40, 32'hCAFE_F00D);
    jtag_pulse(0, 8'h40, 1'b0, 0); step(2);
    mc = mon_cnt;
    jtag_pulse(2, 0, 1'b0, 0);
    step(1);
    reset = 1'b1; rc = rden_cnt;
    checks++; if (av.waitrequest !== 1'b1 || ram_rden !== 1'b0 || ram_wren !== 1'b0) begin errors++;
      $display("FAIL rst_mid_outputs: got wr=%b rden=%b wren=%b want 1/0/0", av.waitrequest, ram_rden, ram_wren); end
    step(1);
    reset = 1'b0; ref_jaddr = '0; ref_err = 1'b0;
    step(6);
    checks++; if (mon_cnt !== mc) begin errors++; $display("FAIL rst_mid_mon: got %0d pulses want 0", mon_cnt - mc); end
    checks++; if (rden_cnt !== rc) begin errors++; $display("FAIL rst_mid_rden: got %0d strobes want 0", rden_cnt - rc); end
    checks++; if (av.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_mid_waitreq: got %b want 1", av.waitrequest); end
    ref_jtag(2, 0, 1'b0, 0, 1'b1, en, ev);
    jtag_op(2, 0, 1'b0, 0, n, v);
    checks++; if (n !== 1 || v !== ev) begin errors++; $display("FAIL rst_mid_addr0: got %0d/%h want 1/%h", n, v, ev); end
    cpu_op(1'b0, 8'h40, 0, 4'hF, rd, lat);
    checks++; if (lat !== 3 || rd !== ref_mem[8'h40]) begin errors++;
      $display("FAIL rst_mid_idle: got %0d/%h want 3/%h", lat, rd, ref_mem[8'h40]); end
  endtask

  task automatic test_random();
    int kind, n, en, lat, bad; logic [7:0] a; logic [31:0] d, v, ev, rd; logic [3:0] be; logic rdf;
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 4); a = 8'($urandom); d = $urandom; be = 4'($urandom); rdf = 1'($urandom);
      debugack = ($urandom_range(0, 5) != 0);
      if (kind >= 3) begin
        cpu_op(kind == 4, a, d, be, rd, lat);
        if (kind == 4) ref_cpu_wr(a, d, be);
        checks++; if (lat !== (kind == 4 ? 2 : 3)) begin errors++; $display("FAIL rnd_cpu_lat it%0d: got %0d", it, lat); end
        if (kind == 3) begin
          checks++; if (rd !== ref_mem[a]) begin errors++; $display("FAIL rnd_cpu_rd it%0d: got %h want %h", it, rd, ref_mem[a]); end
        end
      end else begin
        ref_jtag(kind, a, rdf, d, debugack, en, ev);
        jtag_op(kind, a, rdf, d, n, v);
        checks++; if (n !== en || (en == 1 && v !== ev)) begin errors++;
          $display("FAIL rnd_jtag it%0d: got %0d/%h want %0d/%h", it, n, v, en, ev); end
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL rnd_ram_image: got %0d bad words want 0", bad); end
    checks++; if (jtag_err !== ref_err || jtag_overrun !== 1'b0) begin errors++;
      $display("FAIL rnd_flags: got err=%b ovr=%b want %b/0", jtag_err, jtag_overrun, ref_err); end
  endtask

  initial begin
    av.address = '0; av.read = 1'b0; av.write = 1'b0; av.writedata = '0; av.byteenable = '0;
    ram_rdata = '0;
    #1;
    test_reset();
    test_cpu_read();
    test_jtag_write_wrap();
    test_tie();
    test_overrun();
    test_debugack();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
